// File: rtl/amiga_reset_sequencer.sv
// Reset / override sequencer for the A1000 system model: power-on hold, keyboard
// reset, filtered external-reset detection, override channels and a C1 tick budget.
module amiga_reset_sequencer #(
    parameter int HOLD_CYCLES    = 100,
    parameter int KB_HOLD_CYCLES = 500,
    parameter int TICK_LIMIT     = 1000,
    parameter int TICK_W         = 16,
    parameter int OVR_CH         = 1
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              C1,
    input  logic              RST_SENSE,
    input  logic              KB_RST_REQ,
    input  logic [OVR_CH-1:0] OVR_REQ,
    output logic              RST_OE,
    output logic [OVR_CH-1:0] OVR_OE,
    output logic [TICK_W-1:0] TICKS,
    output logic              DONE,
    output logic [1:0]        STATE
);

    localparam logic [1:0] ST_HOLD   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_KBHOLD = 2'd2;
    localparam logic [1:0] ST_FIN    = 2'd3;

    // One shared counter serves both hold phases; it only ever reaches max-1.
    localparam int CNT_MAX = (HOLD_CYCLES > KB_HOLD_CYCLES) ? HOLD_CYCLES : KB_HOLD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0]  HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  KB_LAST   = CNT_W'(KB_HOLD_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_END  = TICK_W'(TICK_LIMIT);

    logic [1:0]        state_reg,     state_next;
    logic [CNT_W-1:0]  cnt_reg,       cnt_next;
    logic [TICK_W-1:0] ticks_reg,     ticks_next;
    logic              done_reg,      done_next;
    logic              rst_oe_reg,    rst_oe_next;
    logic [OVR_CH-1:0] ovr_oe_reg,    ovr_oe_next;
    logic              sense_low_reg, sense_low_next;
    logic              c1_prev_reg;
    logic              kb_prev_reg;

    logic              tick_event;
    logic              kb_edge;
    logic              sense_detect;
    logic              stay_run;
    logic [TICK_W-1:0] ticks_inc;

    assign tick_event   = C1 & ~c1_prev_reg;
    assign kb_edge      = KB_RST_REQ & ~kb_prev_reg;
    // Second consecutive low sample while we are not driving the line ourselves.
    assign sense_detect = (state_reg == ST_RUN) & ~rst_oe_reg & ~RST_SENSE & sense_low_reg;
    assign ticks_inc    = ticks_reg + TICK_W'(1);

    // State register
    always_ff @(posedge CLK) begin
        c1_prev_reg <= C1;
        kb_prev_reg <= KB_RST_REQ;
        if (RESET) begin
            state_reg     <= ST_HOLD;
            cnt_reg       <= '0;
            ticks_reg     <= '0;
            done_reg      <= 1'b0;
            rst_oe_reg    <= 1'b1;
            ovr_oe_reg    <= '0;
            sense_low_reg <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            ticks_reg     <= ticks_next;
            done_reg      <= done_next;
            rst_oe_reg    <= rst_oe_next;
            ovr_oe_reg    <= ovr_oe_next;
            sense_low_reg <= sense_low_next;
        end
    end

    // Next-state logic; event priority is KB edge, then sense detect, then tick.
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        ticks_next = ticks_reg;
        done_next  = done_reg;
        unique case (state_reg)
            ST_HOLD: begin
                if (kb_edge) begin
                    state_next = ST_KBHOLD;
                    cnt_next   = '0;
                    ticks_next = '0;
                end else if (cnt_reg == HOLD_LAST) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (kb_edge) begin
                    state_next = ST_KBHOLD;
                    cnt_next   = '0;
                    ticks_next = '0;
                end else if (sense_detect) begin
                    state_next = ST_HOLD;
                    cnt_next   = '0;
                    ticks_next = '0;
                end else if (tick_event) begin
                    ticks_next = ticks_inc;
                    if (ticks_inc == TICK_END) begin
                        done_next  = 1'b1;
                        state_next = ST_FIN;
                    end
                end
            end
            ST_KBHOLD: begin
                // A fresh key press restarts the minimum hold; a held key extends it.
                if (kb_edge) begin
                    cnt_next = '0;
                end else if (cnt_reg != KB_LAST) begin
                    cnt_next = cnt_reg + CNT_W'(1);
                end else if (!KB_RST_REQ) begin
                    state_next = ST_RUN;
                    cnt_next   = '0;
                end
            end
            default: begin
                state_next = ST_FIN;
            end
        endcase
    end

    // Output logic: registered outputs follow the state being entered.
    always_comb begin
        stay_run       = (state_reg == ST_RUN) && (state_next == ST_RUN);
        rst_oe_next    = (state_next == ST_HOLD) || (state_next == ST_KBHOLD);
        sense_low_next = stay_run & ~RST_SENSE;
    end

    for (genvar gi = 0; gi < OVR_CH; gi++) begin : g_ovr
        assign ovr_oe_next[gi] = stay_run & OVR_REQ[gi];
    end

    assign RST_OE = rst_oe_reg;
    assign OVR_OE = ovr_oe_reg;
    assign TICKS  = ticks_reg;
    assign DONE   = done_reg;
    assign STATE  = state_reg;

endmodule
